// File: rtl/dmem_arbiter.sv
// Round-robin CPU/host arbiter for the single-port data memory with bounded host burst lock.
// Grants are combinational, read data returns one cycle after the grant, and a losing requester simply holds its request.
module dmem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 9,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    input  logic          h_lock,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [7:0]    stall_cnt
);
    typedef enum logic {ARB, LOCK} state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t     state, state_nxt;
    logic       last_h, last_h_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic       c_win, h_win;
    logic       tag_vld, tag_h;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB;
            last_h    <= 1'b1;
            burst_cnt <= '0;
            tag_vld   <= 1'b0;
            tag_h     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            last_h    <= last_h_nxt;
            burst_cnt <= burst_nxt;
            tag_vld   <= (c_gnt & ~c_we) | (h_gnt & ~h_we);
            tag_h     <= h_gnt;
            if (c_req && !c_gnt && stall_cnt != 8'hFF)
                stall_cnt <= stall_cnt + 8'd1;
        end
    end

    always_comb begin
        c_win      = 1'b0;
        h_win      = 1'b0;
        state_nxt  = state;
        last_h_nxt = last_h;
        burst_nxt  = burst_cnt;
        if (state == LOCK && h_req && h_lock) begin
            // Once the host has used its burst budget, a waiting CPU gets one slot.
            if (c_req && burst_cnt == BURST_MAX) begin
                c_win     = 1'b1;
                burst_nxt = '0;
            end else begin
                h_win = 1'b1;
                if (c_req)
                    burst_nxt = burst_cnt + 4'd1;
            end
        end else begin
            // Leaving LOCK arbitrates as if the host owned the last slot.
            if (c_req && (!h_req || last_h || state == LOCK))
                c_win = 1'b1;
            else if (h_req)
                h_win = 1'b1;
            state_nxt = ARB;
            burst_nxt = '0;
            if (h_win && h_lock) begin
                state_nxt = LOCK;
                burst_nxt = 4'd1;
            end
        end
        if (c_win)
            last_h_nxt = 1'b0;
        if (h_win)
            last_h_nxt = 1'b1;
    end

    assign c_gnt  = c_win & reset;
    assign h_gnt  = h_win & reset;
    assign mem_en = c_gnt | h_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_gnt) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (h_gnt) begin
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end
    end

    assign c_rvalid = tag_vld & ~tag_h;
    assign h_rvalid = tag_vld & tag_h;
    assign c_rdata  = c_rvalid ? mem_rdata : '0;
    assign h_rdata  = h_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle vector table with a read-return scoreboard, plus reset and saturation sequences.
module tb_dmem_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       c_req, c_we, h_req, h_we, h_lock;
    logic [7:0] c_addr, h_addr;
    logic [8:0] c_wdata, h_wdata;
    logic       c_gnt, c_rvalid, h_gnt, h_rvalid;
    logic [8:0] c_rdata, h_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr;
    logic [8:0] mem_wdata;
    logic [8:0] mem_rdata;
    logic [7:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       cr, cw;
        logic [7:0] ca;
        logic [8:0] cd;
        logic       hr, hw;
        logic [7:0] ha;
        logic [8:0] hd;
        logic       hl;
        logic       ecg, ehg;
    } vec_t;

    typedef struct {
        logic       is_h;
        logic [8:0] data;
    } rd_t;

    vec_t       tbl[$];
    rd_t        exp_q[$];
    logic [8:0] mem_model [256];
    logic [8:0] ref_mem   [256];
    int         exp_stall;

    dmem_arbiter #(.AW(8), .DW(9), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic cr, input logic cw, input logic [7:0] ca,
                               input logic [8:0] cd, input logic hr, input logic hw,
                               input logic [7:0] ha, input logic [8:0] hd, input logic hl,
                               input logic ecg, input logic ehg);
        vec_t r;
        r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
        r.hr = hr; r.hw = hw; r.ha = ha; r.hd = hd; r.hl = hl;
        r.ecg = ecg; r.ehg = ehg;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        c_req = x.cr; c_we = x.cw; c_addr = x.ca; c_wdata = x.cd;
        h_req = x.hr; h_we = x.hw; h_addr = x.ha; h_wdata = x.hd; h_lock = x.hl;
    endtask

    task automatic run_vec(input vec_t x);
        rd_t        e;
        logic       e_we;
        logic [7:0] e_addr;
        logic [8:0] e_wdata;
        @(negedge clk);
        drive(x);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("c_rvalid", c_rvalid, !e.is_h);
            chk("h_rvalid", h_rvalid, e.is_h);
            if (e.is_h) chk("h_rdata", h_rdata, e.data);
            else        chk("c_rdata", c_rdata, e.data);
        end else begin
            chk("c_rvalid_idle", c_rvalid, 0);
            chk("h_rvalid_idle", h_rvalid, 0);
        end
        chk("stall_cnt", stall_cnt, exp_stall);
        e_we    = x.ecg ? x.cw : (x.ehg ? x.hw : 1'b0);
        e_addr  = x.ecg ? x.ca : (x.ehg ? x.ha : 8'h0);
        e_wdata = x.ecg ? x.cd : (x.ehg ? x.hd : 9'h0);
        chk("c_gnt", c_gnt, x.ecg);
        chk("h_gnt", h_gnt, x.ehg);
        chk("mem_en", mem_en, x.ecg | x.ehg);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        if (x.ecg | x.ehg) begin
            if (e_we) ref_mem[e_addr] = e_wdata;
            else      exp_q.push_back('{is_h: x.ehg, data: ref_mem[e_addr]});
        end
        if (x.cr && !x.ecg && exp_stall < 255) exp_stall++;
    endtask

    initial begin
        vec_t idle;
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = 9'(i) ^ 9'h002;
            ref_mem[i]   = 9'(i) ^ 9'h002;
        end
        mem_rdata = '0;
        exp_stall = 0;
        idle = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Outputs must stay quiet in reset even with requests asserted
        reset = 1'b0;
        drive(v(1, 0, 8'h11, 0, 1, 1, 8'h22, 9'h1FF, 1, 0, 0));
        repeat (2) @(negedge clk);
        #1;
        chk("rst_c_gnt", c_gnt, 0);
        chk("rst_h_gnt", h_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_stall", stall_cnt, 0);
        drive(idle);
        @(negedge clk);
        reset = 1'b1;

        tbl.push_back(idle);
        for (int k = 0; k < 4; k++)
            tbl.push_back(v(1, 0, 8'(60 + k), 0, 1, 0, 8'(70 + k), 0, 0, k % 2 == 0, k % 2 == 1));
        tbl.push_back(v(1, 0, 8'd3, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(idle);
        for (int k = 0; k < 10; k++)
            tbl.push_back(v(1, 0, 8'(16 + k), 0, 1, 0, 8'(32 + k), 0, 1,
                            k == 4 || k == 9, !(k == 4 || k == 9)));
        tbl.push_back(v(1, 0, 8'd40, 0, 1, 0, 8'd41, 0, 0, 1, 0));
        tbl.push_back(idle);
        tbl.push_back(v(0, 0, 0, 0, 1, 1, 8'd1, 9'h007, 0, 0, 1));
        tbl.push_back(v(1, 0, 8'd1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(idle);
        for (int k = 0; k < 6; k++)
            tbl.push_back(v(0, 0, 0, 0, 1, 0, 8'(50 + k), 0, 1, 0, 1));
        for (int k = 0; k < 4; k++)
            tbl.push_back(v(1, 0, 8'(80 + k), 0, 1, 0, 8'(90 + k), 0, 1, k == 3, k != 3));
        tbl.push_back(idle);
        tbl.push_back(idle);

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i]);
        chk("queue_drained", exp_q.size(), 0);

        // Long host-locked burst drives the stall counter into saturation
        @(negedge clk);
        drive(v(1, 0, 8'h10, 0, 1, 0, 8'h20, 0, 1, 0, 0));
        repeat (400) @(negedge clk);
        drive(idle);
        #1;
        chk("stall_sat", stall_cnt, 255);
        @(negedge clk);
        drive(v(1, 0, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        chk("stall_hold", stall_cnt, 255);

        // Reset lands while a CPU read is in flight
        @(negedge clk);
        drive(v(1, 0, 8'd5, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("mid_c_gnt", c_gnt, 1);
        #1;
        reset = 1'b0;
        @(negedge clk);
        drive(idle);
        reset = 1'b1;
        #1;
        chk("mid_c_rvalid0", c_rvalid, 0);
        chk("mid_stall", stall_cnt, 0);
        @(negedge clk);
        #1;
        chk("mid_c_rvalid1", c_rvalid, 0);
        chk("mid_h_rvalid1", h_rvalid, 0);
        @(negedge clk);
        drive(v(1, 0, 8'd6, 0, 1, 0, 8'd7, 0, 1, 0, 0));
        #1;
        chk("post_rst_c_gnt", c_gnt, 1);
        chk("post_rst_h_gnt", h_gnt, 0);
        @(negedge clk);
        drive(idle);
        #1;
        chk("post_rst_c_rvalid", c_rvalid, 1);
        chk("post_rst_c_rdata", c_rdata, 9'(6) ^ 9'h002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 9-bit data memory between two requesters: the CPU load/store path (port C) and a host/debug loader port (port H).
- Sits between the core's memory stage and the data memory inside top_level.
- Uses round-robin arbitration, plus a bounded host burst-lock mode so the host can stream preload data without permanently starving the CPU.
- Provides 1-cycle read data return and a CPU stall counter for performance checks.

Parameters:
- AW, 8, address width in bits.
- DW, 9, data width in bits.
- MAX_BURST, 4, maximum consecutive locked host grants while the CPU is waiting (range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- c_req  in  1  CPU requests an access this cycle.
- c_we  in  1  1 = write, 0 = read.
- c_addr  in  AW  CPU address.
- c_wdata  in  DW  CPU write data.
- c_gnt  out  1  CPU access issued to memory this cycle.
- c_rvalid  out  1  CPU read data valid this cycle.
- c_rdata  out  DW  CPU read data.
- h_req, h_we, h_addr, h_wdata  in  1/1/AW/DW  host request fields, same meaning as CPU.
- h_lock  in  1  host requests burst lock.
- h_gnt, h_rvalid, h_rdata  out  1/1/DW  host counterparts of the CPU outputs.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  synchronous read data, valid the cycle after mem_en=1 with mem_we=0.
- stall_cnt  out  8  saturating count of cycles where c_req=1 and c_gnt=0.

Behaviour:
- Reset (reset=0, async):
  - state=ARB, last_owner=H (so the CPU wins the first tie), burst_cnt=0, stall_cnt=0.
  - Pending read tags cleared.
  - All gnt/rvalid/mem_en/mem_we = 0; rdata and mem_addr/mem_wdata = 0.
  - Outputs are forced to these values while reset=0, regardless of request inputs.
- Grants:
  - Combinational from the current cycle's requests and registered state.
  - At most one gnt per cycle.
  - mem_en = c_gnt | h_gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the winner; all zero when there is no winner.
- State ARB:
  - Single requester wins.
  - Both requesting: the port not equal to last_owner wins.
  - last_owner updates to the winner at each grant.
  - h_gnt with h_lock=1 moves the FSM to LOCK with burst_cnt=1.
- State LOCK:
  - The host has absolute priority while h_req=1 and h_lock=1.
  - Each host grant made while c_req=1 increments burst_cnt.
  - When burst_cnt==MAX_BURST and c_req=1: the next cycle's grant goes to the CPU regardless of host requests. burst_cnt resets to 0 and the FSM stays in LOCK.
  - Host grants made while c_req=0 do not advance burst_cnt.
  - If h_lock=0 or h_req=0 in any cycle, the FSM returns to ARB for the next cycle. The current cycle is arbitrated as in ARB, with last_owner=H.
- Read return:
  - A read grant registers a tag (C or H).
  - Next cycle: the tagged port's rvalid=1 and its rdata=mem_rdata.
  - The untagged port sees rdata=0 and rvalid=0.
  - Back-to-back reads are fully pipelined: a new grant can issue in the same cycle an earlier read returns.
- Writes: complete on the grant cycle; there is no rvalid for writes.
- Same-address ordering: a write granted in cycle N is visible to a read granted in cycle N+1, because memory order equals grant order.
- stall_cnt: +1 each cycle where c_req & ~c_gnt; saturates at 255; never wraps.
- Reset mid-operation: any in-flight read tag is discarded; no rvalid is produced after reset deasserts.
- Address and data are passed through unmodified; no width conversion.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then release with no requests → all outputs 0, stall_cnt=0.
- CPU read: c_req=1, c_we=0, c_addr=3, mem_rdata next cycle=9'h001 → c_gnt=1 in cycle N; mem_addr=3 and mem_we=0 in cycle N; c_rvalid=1 and c_rdata=1 in cycle N+1; h_rvalid=0 throughout.
- Tie round-robin: both req continuous reads, h_lock=0, starting from reset → grants alternate C,H,C,H; each rvalid lands on the matching port one cycle later; stall_cnt=2 after 4 cycles.
- Host burst lock, MAX_BURST=4: h_req=h_lock=1 and c_req=1 held → grant pattern H,H,H,H,C,H,H,H,H,C; stall_cnt increments on every H cycle.
- Write-then-read: host writes 9'h007 to addr 1, CPU reads addr 1 in the next cycle → mem_we=1 and mem_wdata=7 in cycle N; CPU granted in cycle N+1 with mem_addr=1; c_rdata=7 in cycle N+2 (memory model).
- Reset mid-read: CPU read granted, then reset=0 asserted before the next edge → no c_rvalid after release; state is ARB and the CPU wins the first subsequent tie.
